// File: rtl/result_serializer_if.sv
// Handshake bundle between the encrypter array / QSPI host and the result serializer.
interface result_serializer_if #(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32
);
  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] enc_data;
  logic [NUM_ENCRYPTERS-1:0]                 enc_valid;
  logic [NUM_ENCRYPTERS-1:0]                 enc_ack;
  logic                                      host_ready;
  logic                                      flush;
  logic [3:0]                                qspi_data_out;
  logic                                      qspi_out_sending;
  logic                                      state_out;
  logic [15:0]                               packets_out;

  modport slave (
    input  enc_data, enc_valid, host_ready, flush,
    output enc_ack, qspi_data_out, qspi_out_sending, state_out, packets_out
  );

  modport master (
    output enc_data, enc_valid, host_ready, flush,
    input  enc_ack, qspi_data_out, qspi_out_sending, state_out, packets_out
  );
endinterface

// File: rtl/result_serializer.sv
// Round-robin collector of encrypter results, streamed LSB nibble first onto QSPI; first nibble
// one cycle after capture, then one per host_ready edge; host_ready=0 stalls, one-word prefetch hides word gaps.
module result_serializer #(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  result_serializer_if.slave bus
);
  localparam int NIBBLES = ENCRYPTER_WIDTH / 4;
  localparam int PTR_W   = (NUM_ENCRYPTERS > 1) ? $clog2(NUM_ENCRYPTERS) : 1;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ENCRYPTERS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic [PTR_W-1:0]            ptr, ptr_nxt, ptr_inc;
  logic [IDX_W-1:0]            idx, idx_nxt;
  logic [ENCRYPTER_WIDTH-1:0]  shreg, shreg_nxt;
  logic [ENCRYPTER_WIDTH-1:0]  pf_dat, pf_dat_nxt;
  logic                        pf_vld, pf_vld_nxt;
  logic [NUM_ENCRYPTERS-1:0]   ack, ack_nxt;
  logic                        sending, sending_nxt;
  logic [15:0]                 pkts, pkts_nxt;
  logic [3:0]                  dout, dout_nxt;
  logic                        cand_vld;
  logic [ENCRYPTER_WIDTH-1:0]  cand_dat;
  logic                        take;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      ptr     <= '0;
      idx     <= '0;
      shreg   <= '0;
      pf_dat  <= '0;
      pf_vld  <= 1'b0;
      ack     <= '0;
      sending <= 1'b0;
      pkts    <= '0;
      dout    <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      pf_dat  <= pf_dat_nxt;
      pf_vld  <= pf_vld_nxt;
      ack     <= ack_nxt;
      sending <= sending_nxt;
      pkts    <= pkts_nxt;
      dout    <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    pf_dat_nxt  = pf_dat;
    pf_vld_nxt  = pf_vld;
    ack_nxt     = '0;
    sending_nxt = sending;
    pkts_nxt    = pkts;
    dout_nxt    = dout;
    take        = 1'b0;

    // A result whose ack is still on the wire is the one just taken; never take it twice.
    cand_vld = bus.enc_valid[ptr] & ~ack[ptr];
    cand_dat = bus.enc_data[int'(ptr)*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH];
    ptr_inc  = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;

    if (bus.flush) begin
      state_nxt   = IDLE;
      ptr_nxt     = '0;
      idx_nxt     = '0;
      pf_vld_nxt  = 1'b0;
      sending_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_vld) begin
            take        = 1'b1;
            shreg_nxt   = cand_dat;
            idx_nxt     = '0;
            state_nxt   = SHIFT;
            sending_nxt = 1'b1;
          end
        end
        SHIFT: begin
          if (bus.host_ready && idx == IDX_LAST) begin
            pkts_nxt = pkts + 16'd1;
            idx_nxt  = '0;
            if (pf_vld) begin
              shreg_nxt  = pf_dat;
              pf_vld_nxt = 1'b0;
            end else if (cand_vld) begin
              take      = 1'b1;
              shreg_nxt = cand_dat;
            end else begin
              state_nxt   = IDLE;
              sending_nxt = 1'b0;
            end
          end else begin
            if (bus.host_ready) idx_nxt = idx + 1'b1;
            if (!pf_vld && cand_vld) begin
              take       = 1'b1;
              pf_dat_nxt = cand_dat;
              pf_vld_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (take) begin
      ack_nxt[ptr] = 1'b1;
      ptr_nxt      = ptr_inc;
    end

    // On return to IDLE the last nibble stays on the pins.
    if (state_nxt == SHIFT) dout_nxt = shreg_nxt[int'(idx_nxt)*4 +: 4];
  end

  assign bus.enc_ack          = ack;
  assign bus.qspi_data_out    = dout;
  assign bus.qspi_out_sending = sending;
  assign bus.state_out        = (state == SHIFT);
  assign bus.packets_out      = pkts;
endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: directed scenarios plus random traffic against a queue-based nibble model.
module tb_result_serializer;
  logic clk;
  logic reset;

  result_serializer_if #(.NUM_ENCRYPTERS(4), .ENCRYPTER_WIDTH(32)) bus ();

  result_serializer #(.NUM_ENCRYPTERS(4), .ENCRYPTER_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Encrypter side: each encrypter holds a small FIFO of pending results.
  logic [31:0] enc_mem [4][16];
  int          head [4];
  int          tail [4];

  // Expected nibble stream: bit 4 marks the last nibble of a word.
  logic [4:0]  expq [$];
  int          ptr_m;
  logic [15:0] pkts_m;
  logic [3:0]  last_nib;
  bit          hold_vld;
  logic [15:0] base;
  int          rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input int i, input logic [31:0] w);
    enc_mem[i][tail[i] % 16] = w;
    tail[i]++;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 4; i++) s += tail[i] - head[i];
    return s;
  endfunction

  task automatic drive_enc();
    for (int i = 0; i < 4; i++) begin
      bus.enc_valid[i]          = (head[i] != tail[i]);
      bus.enc_data[i*32 +: 32]  = (head[i] != tail[i]) ? enc_mem[i][head[i] % 16] : 32'h0;
    end
  endtask

  task automatic observe(input bit after_flush);
    logic [3:0]  ack;
    logic [31:0] w;
    bit          busy;
    ack = bus.enc_ack;
    chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
    if (after_flush) chk("ack_after_flush", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (ack[i]) begin
        chk("ack_order", 32'(i), 32'(ptr_m));
        ptr_m = (ptr_m + 1) % 4;
        if (head[i] != tail[i]) begin
          w = enc_mem[i][head[i] % 16];
          head[i]++;
          for (int n = 0; n < 8; n++) expq.push_back({n == 7, w[n*4 +: 4]});
        end
      end
    end
    busy = (expq.size() != 0);
    chk("sending", 32'(bus.qspi_out_sending), 32'(busy));
    chk("state_out", 32'(bus.state_out), 32'(busy));
    chk("packets", 32'(bus.packets_out), 32'(pkts_m));
    if (!busy && hold_vld) chk("data_hold", 32'(bus.qspi_data_out), 32'(last_nib));
  endtask

  // One clock: drive at negedge, score the transfer, clock, then observe at the next negedge.
  task automatic step(input bit hr, input bit fl);
    logic [4:0] e;
    bus.host_ready = hr;
    bus.flush      = fl;
    drive_enc();
    if (!fl && hr && bus.qspi_out_sending && expq.size() != 0) begin
      e = expq.pop_front();
      chk("nibble", 32'(bus.qspi_data_out), 32'(e[3:0]));
      last_nib = e[3:0];
      hold_vld = 1'b1;
      if (e[4]) pkts_m++;
    end
    @(posedge clk);
    if (fl) begin
      expq.delete();
      ptr_m    = 0;
      hold_vld = 1'b0;
    end
    @(negedge clk);
    observe(fl);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    ptr_m    = 0;
    pkts_m   = '0;
    last_nib = '0;
    hold_vld = 1'b0;
    bus.enc_data   = '0;
    bus.enc_valid  = '0;
    bus.host_ready = 1'b0;
    bus.flush      = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sending", 32'(bus.qspi_out_sending), 32'd0);
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk("rst_packets", 32'(bus.packets_out), 32'd0);
    chk("rst_data", 32'(bus.qspi_data_out), 32'd0);
    chk("rst_ack", 32'(bus.enc_ack), 32'd0);
    reset = 1'b1;

    // Single word, host always ready.
    base = pkts_m;
    push_word(0, 32'h8765_4321);
    step(1, 0);
    chk("t2_first_nibble", 32'(bus.qspi_data_out), 32'h1);
    for (int k = 0; k < 8; k++) step(1, 0);
    chk("t2_packets", 32'(bus.packets_out), 32'(base + 16'd1));
    chk("t2_idle", 32'(bus.qspi_out_sending), 32'd0);
    chk("t2_last_held", 32'(bus.qspi_data_out), 32'h8);

    // enc1 arrives early but must wait behind enc0.
    step(1, 1);
    push_word(1, 32'hBBBB_1111);
    for (int k = 0; k < 5; k++) step(1, 0);
    chk("t3_waiting", 32'(bus.qspi_out_sending), 32'd0);
    push_word(0, 32'hAAAA_0000);
    for (int k = 0; k < 18; k++) step(1, 0);
    chk("t3_packets", 32'(bus.packets_out), 32'(base + 16'd3));

    // All four valid: 32 back-to-back nibbles.
    step(1, 1);
    base = pkts_m;
    push_word(0, 32'h0123_4567);
    push_word(1, 32'h89AB_CDEF);
    push_word(2, 32'hFEDC_BA98);
    push_word(3, 32'h7654_3210);
    step(1, 0);
    for (int k = 1; k <= 32; k++) begin
      chk("t4_contiguous", 32'(bus.qspi_out_sending), 32'd1);
      step(1, 0);
    end
    chk("t4_packets", 32'(bus.packets_out), 32'(base + 16'd4));
    chk("t4_idle", 32'(bus.qspi_out_sending), 32'd0);

    // Host stall mid-word; pointer must already be back at encrypter 0.
    base = pkts_m;
    push_word(0, 32'h8765_4321);
    step(1, 0);
    for (int k = 0; k < 4; k++) step(1, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0);
      chk("t5_held", 32'(bus.qspi_data_out), 32'h5);
    end
    for (int k = 0; k < 4; k++) step(1, 0);
    chk("t5_packets", 32'(bus.packets_out), 32'(base + 16'd1));

    // Flush with the prefetch buffer full.
    step(1, 1);
    base = pkts_m;
    push_word(0, 32'h1357_9BDF);
    push_word(1, 32'h2468_ACE0);
    for (int k = 0; k < 4; k++) step(1, 0);
    step(1, 1);
    chk("t6_sending", 32'(bus.qspi_out_sending), 32'd0);
    chk("t6_state", 32'(bus.state_out), 32'd0);
    chk("t6_packets", 32'(bus.packets_out), 32'(base));
    push_word(0, 32'hC0FF_EE42);
    for (int k = 0; k < 10; k++) step(1, 0);
    chk("t6_after", 32'(bus.packets_out), 32'(base + 16'd1));

    // Asynchronous reset while shifting.
    step(1, 1);
    for (int i = 0; i < 4; i++) push_word(i, 32'hD000_0000 | 32'(i));
    for (int k = 0; k < 5; k++) step(1, 0);
    #2 reset = 1'b0;
    #1;
    chk("t1_sending", 32'(bus.qspi_out_sending), 32'd0);
    chk("t1_state", 32'(bus.state_out), 32'd0);
    chk("t1_packets", 32'(bus.packets_out), 32'd0);
    chk("t1_data", 32'(bus.qspi_data_out), 32'd0);
    chk("t1_ack", 32'(bus.enc_ack), 32'd0);
    expq.delete();
    ptr_m    = 0;
    pkts_m   = '0;
    hold_vld = 1'b0;
    @(negedge clk);
    chk("t1_ack_in_reset", 32'(bus.enc_ack), 32'd0);
    reset = 1'b1;
    push_word(0, 32'hE000_0000);
    push_word(1, 32'hE000_0001);
    for (int k = 0; k < 200 && (pending() != 0 || expq.size() != 0); k++) step(1, 0);
    chk("t1_drained", 32'(pending() + expq.size()), 32'd0);

    // Random traffic in issue order with random host stalls.
    rr = ptr_m;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 4) == 0 && (tail[rr] - head[rr]) < 16) begin
        push_word(rr, $urandom);
        rr = (rr + 1) % 4;
      end
      step($urandom_range(0, 3) != 0, 0);
    end
    for (int k = 0; k < 3000 && (pending() != 0 || expq.size() != 0); k++) step(1, 0);
    chk("rand_drained", 32'(pending() + expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
